// File: rtl/control_pkg.sv
// Shared types for the control sequencer: FSM states, instruction classes, strobe bundle
// and the opcode classifier.
package control_pkg;

  localparam int unsigned OP_W = 8;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WAIT  = 2'd2,
    IRQ   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CL_SIMPLE = 3'd0,
    CL_JMP    = 3'd1,
    CL_MEM    = 3'd2,
    CL_ALU    = 3'd3,
    CL_SIG    = 3'd4,
    CL_SYS    = 3'd5
  } class_t;

  localparam logic [2:0] JMP_PAT = 3'b111;
  localparam logic [1:0] MEM_PAT = 2'b10;
  localparam logic [1:0] ALU_PAT = 2'b01;
  localparam logic [4:0] SIG_PAT = 5'b00011;
  localparam logic [4:0] SYS_PAT = 5'b00010;

  typedef struct packed {
    logic m;
    logic j;
    logic mw;
    logic mc;
    logic rd;
    logic wr;
    logic wa;
    logic wc;
  } strobes_t;

  localparam strobes_t STRB_JUMP = '{m: 1'b0, j: 1'b1, mw: 1'b0, mc: 1'b0,
                                     rd: 1'b0, wr: 1'b0, wa: 1'b0, wc: 1'b0};

  // Class priority: JMP overlaps nothing else once MEM is restricted to op[7:6]=10.
  function automatic class_t op_class(input logic [OP_W-1:0] op);
    if (op[7:5] == JMP_PAT) return CL_JMP;
    if (op[7:6] == MEM_PAT) return CL_MEM;
    if (op[7:6] == ALU_PAT) return CL_ALU;
    if (op[7:3] == SIG_PAT) return CL_SIG;
    if (op[7:3] == SYS_PAT) return CL_SYS;
    return CL_SIMPLE;
  endfunction

endpackage

// File: rtl/control_seq_if.sv
// Instruction-fetch handshake and data-memory completion between memories and the sequencer.
interface control_seq_if #(
  parameter int unsigned INST_W = 8
);
  logic [INST_W-1:0] inst_in;
  logic              inst_valid;
  logic              inst_ready;
  logic              mem_ready;

  modport master (output inst_in, inst_valid, mem_ready, input inst_ready);
  modport slave  (input inst_in, inst_valid, mem_ready, output inst_ready);
endinterface

// File: rtl/control_decode.sv
// Combinational strobe decoder: (opcode, step index, carry) -> strobe bundle and signal pulses.
// The step index is the one in effect at the registering edge; its output shows one step later.
module control_decode import control_pkg::*; #(
  parameter int unsigned MEM_CYC  = 2,
  parameter int unsigned SIG_SELW = 3,
  localparam int unsigned SIG_N   = 1 << SIG_SELW,
  localparam int unsigned CYC_W   = $clog2(MEM_CYC + 1)
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [CYC_W-1:0] i_cyc,
  input  logic             i_carry,
  output strobes_t         o_strb_c,
  output logic [SIG_N-1:0] o_sig_c
);

  class_t w_class;
  logic   w_mem_cyc;
  logic   w_mem_acc;

  assign w_class   = op_class(i_op);
  assign w_mem_cyc = (i_cyc >= CYC_W'(1)) && (i_cyc <= CYC_W'(MEM_CYC - 1));
  assign w_mem_acc = (i_cyc == CYC_W'(MEM_CYC - 1));

  always_comb begin
    o_strb_c = '0;
    o_sig_c  = '0;
    case (w_class)
      CL_JMP: o_strb_c.j = ~(i_op[4] & i_carry);
      CL_MEM: begin
        o_strb_c.mc = w_mem_cyc;
        o_strb_c.m  = w_mem_acc;
        o_strb_c.mw = w_mem_acc & i_op[5];
        o_strb_c.wa = w_mem_acc & ~i_op[5];
      end
      CL_ALU: begin
        o_strb_c.wa = 1'b1;
        o_strb_c.wc = i_op[4];
      end
      CL_SIG: o_sig_c = SIG_N'(1) << i_op[SIG_SELW-1:0];
      CL_SIMPLE: begin
        if (!i_op[4]) begin
          o_strb_c.rd = i_op[2];
          o_strb_c.wr = i_op[3];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// Registered multi-cycle control sequencer: instruction register, step counter, memory stall.
// Interrupt support (IRQ state, ie register) is compiled in when IRQ_ENABLE_EN is defined.
module control_seq import control_pkg::*; #(
  parameter int unsigned INST_W   = 8,
  parameter int unsigned MEM_CYC  = 2,
  parameter int unsigned SIG_SELW = 3,
  localparam int unsigned SIG_N   = 1 << SIG_SELW,
  localparam int unsigned CYC_W   = $clog2(MEM_CYC + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  control_seq_if.slave      bus,
  input  logic              i_carry,
  input  logic              i_irq,
  output logic [INST_W-1:0] o_inst,
  output logic [CYC_W-1:0]  o_cyc,
  output logic              o_m,
  output logic              o_j,
  output logic              o_mw,
  output logic              o_mc,
  output logic              o_rd,
  output logic              o_wr,
  output logic              o_wa,
  output logic              o_wc,
  output logic [SIG_N-1:0]  o_sig
);

  state_t            r_state;
  logic [INST_W-1:0] r_inst;
  logic [CYC_W-1:0]  r_cyc;
  strobes_t          r_strb;
  logic [SIG_N-1:0]  r_sig;
  logic              r_ready;

  logic              w_hs;
  logic [OP_W-1:0]   w_op;
  class_t            w_class;
  logic              w_last;
  logic              w_retire;
  strobes_t          w_strb;
  logic [SIG_N-1:0]  w_sig;

`ifdef IRQ_ENABLE_EN
  logic              r_ie;
`else
  logic              w_unused_irq;
  assign w_unused_irq = i_irq;
`endif

  // Decode the incoming instruction on the issue edge, the held one afterwards.
  assign w_hs    = (r_state == FETCH) && r_ready && bus.inst_valid;
  assign w_op    = w_hs ? bus.inst_in[INST_W-1 -: OP_W] : r_inst[INST_W-1 -: OP_W];
  assign w_class = op_class(w_op);
  assign w_last  = (r_cyc == CYC_W'(MEM_CYC));

  assign w_retire = ((r_state == EXEC) && ((w_class != CL_MEM) || (w_last && bus.mem_ready)))
                 || ((r_state == WAIT) && bus.mem_ready)
                 ||  (r_state == IRQ);

  control_decode #(
    .MEM_CYC  (MEM_CYC),
    .SIG_SELW (SIG_SELW)
  ) u_decode (
    .i_op     (w_op),
    .i_cyc    (r_cyc),
    .i_carry  (i_carry),
    .o_strb_c (w_strb),
    .o_sig_c  (w_sig)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= FETCH;
      r_inst  <= '0;
      r_cyc   <= '0;
      r_strb  <= '0;
      r_sig   <= '0;
      r_ready <= 1'b0;
`ifdef IRQ_ENABLE_EN
      r_ie    <= 1'b0;
`endif
    end else if (w_retire) begin
      r_state <= FETCH;
      r_cyc   <= '0;
      r_strb  <= '0;
      r_sig   <= '0;
      r_ready <= 1'b1;
`ifdef IRQ_ENABLE_EN
      // Clear beats set when a SYS op carries both bits.
      if ((r_state == EXEC) && (w_class == CL_SYS)) r_ie <= ~w_op[1] & (w_op[0] | r_ie);
`endif
    end else begin
      case (r_state)
        FETCH: begin
`ifdef IRQ_ENABLE_EN
          if (i_irq && r_ie) begin
            r_state <= IRQ;
            r_strb  <= STRB_JUMP;
            r_ready <= 1'b0;
            r_ie    <= 1'b0;
          end else
`endif
          if (w_hs) begin
            r_state <= EXEC;
            r_inst  <= bus.inst_in;
            r_cyc   <= CYC_W'(1);
            r_strb  <= w_strb;
            r_sig   <= w_sig;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        EXEC: begin
          // Only a MEM op reaches here; the last step stalls with strobes and cyc frozen.
          if (!w_last) begin
            r_cyc  <= r_cyc + CYC_W'(1);
            r_strb <= w_strb;
            r_sig  <= w_sig;
          end else begin
            r_state <= WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inst_ready = r_ready;
  assign o_inst = r_inst;
  assign o_cyc  = r_cyc;
  assign o_m    = r_strb.m;
  assign o_j    = r_strb.j;
  assign o_mw   = r_strb.mw;
  assign o_mc   = r_strb.mc;
  assign o_rd   = r_strb.rd;
  assign o_wr   = r_strb.wr;
  assign o_wa   = r_strb.wa;
  assign o_wc   = r_strb.wc;
  assign o_sig  = r_sig;

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: directed literal checks, then randomized traffic against a
// frame-queue model of each instruction's visible output cycles. IRQ_ENABLE_EN enables IRQ checks.
module tb_control_seq;

  localparam int unsigned INST_W   = 8;
  localparam int unsigned MEM_CYC  = 2;
  localparam int unsigned SIG_SELW = 3;
  localparam int unsigned SIG_N    = 1 << SIG_SELW;
  localparam int unsigned CYC_W    = $clog2(MEM_CYC + 1);

  localparam int K_SIMPLE = 0, K_JMP = 1, K_MEM = 2, K_ALU = 3, K_SIG = 4, K_SYS = 5;

  // One visible output cycle; strb = {m, j, mw, mc, rd, wr, wa, wc}.
  typedef struct packed {
    logic              ready;
    logic [INST_W-1:0] inst;
    logic [CYC_W-1:0]  cyc;
    logic [7:0]        strb;
    logic [SIG_N-1:0]  sig;
  } frame_t;

  logic clk   = 1'b0;
  logic nrst  = 1'b0;
  logic carry = 1'b0;
  logic irq   = 1'b0;
  logic [INST_W-1:0] inst;
  logic [CYC_W-1:0]  cyc;
  logic m, j, mw, mc, rd, wr, wa, wc;
  logic [SIG_N-1:0]  sig;

  control_seq_if #(.INST_W(INST_W)) bus();

  control_seq #(
    .INST_W   (INST_W),
    .MEM_CYC  (MEM_CYC),
    .SIG_SELW (SIG_SELW)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .bus     (bus),
    .i_carry (carry),
    .i_irq   (irq),
    .o_inst  (inst),
    .o_cyc   (cyc),
    .o_m     (m),
    .o_j     (j),
    .o_mw    (mw),
    .o_mc    (mc),
    .o_rd    (rd),
    .o_wr    (wr),
    .o_wa    (wa),
    .o_wc    (wc),
    .o_sig   (sig)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  frame_t cur = '0;
  frame_t q[$];
  bit     busy = 1'b0;
  bit     is_mem = 1'b0;
  bit     is_sys = 1'b0;
  bit     ie = 1'b0;

  function automatic logic [7:0] strobes();
    return {m, j, mw, mc, rd, wr, wa, wc};
  endfunction

  function automatic int classify(input logic [7:0] op);
    if (op[7:5] == 3'b111)   return K_JMP;
    if (op[7:6] == 2'b10)    return K_MEM;
    if (op[7:6] == 2'b01)    return K_ALU;
    if (op[7:3] == 5'b00011) return K_SIG;
    if (op[7:3] == 5'b00010) return K_SYS;
    return K_SIMPLE;
  endfunction

  // Queue every output cycle an issued instruction must show.
  function automatic void build(input logic [7:0] op, input bit c);
    frame_t f;
    int kind;
    kind   = classify(op);
    is_mem = (kind == K_MEM);
    is_sys = (kind == K_SYS);
    if (is_mem) begin
      for (int k = 1; k <= int'(MEM_CYC); k++) begin
        f      = '0;
        f.inst = op;
        f.cyc  = CYC_W'(k);
        if (k >= 2) f.strb[4] = 1'b1;
        if (k == int'(MEM_CYC)) begin
          f.strb[7] = 1'b1;
          f.strb[5] = op[5];
          f.strb[1] = !op[5];
        end
        q.push_back(f);
      end
    end else begin
      f      = '0;
      f.inst = op;
      f.cyc  = CYC_W'(1);
      case (kind)
        K_JMP: f.strb[6] = !(op[4] && c);
        K_ALU: begin f.strb[1] = 1'b1; f.strb[0] = op[4]; end
        K_SIG: f.sig[op[2:0]] = 1'b1;
        K_SIMPLE: if (!op[4]) begin f.strb[3] = op[2]; f.strb[2] = op[3]; end
        default: ;
      endcase
      q.push_back(f);
    end
  endfunction

  // Advance the expected outputs by one clock given the inputs applied before it.
  function automatic void model_step(input bit n, input bit v, input logic [7:0] ii,
                                     input bit c, input bit ir, input bit mr);
    frame_t f;
    if (!n) begin
      cur = '0; q.delete(); busy = 1'b0; ie = 1'b0;
      return;
    end
    if (busy) begin
      if (q.size() > 0) cur = q.pop_front();
      else if (is_mem && !mr) ;
      else begin
`ifdef IRQ_ENABLE_EN
        if (is_sys) begin
          if (cur.inst[1]) ie = 1'b0;
          else if (cur.inst[0]) ie = 1'b1;
        end
`endif
        f = '0; f.ready = 1'b1; f.inst = cur.inst;
        cur = f; busy = 1'b0;
      end
      return;
    end
`ifdef IRQ_ENABLE_EN
    if (ir && ie) begin
      f = '0; f.inst = cur.inst; f.strb[6] = 1'b1;
      cur = f; ie = 1'b0; busy = 1'b1; is_mem = 1'b0; is_sys = 1'b0;
      return;
    end
`endif
    if (v && cur.ready) begin
      build(ii, c);
      cur  = q.pop_front();
      busy = 1'b1;
    end else begin
      cur.ready = 1'b1;
    end
  endfunction

  // Single compare process: every clock, 1 time unit after the edge.
  always @(posedge clk) begin
    frame_t d;
    #1;
    d = frame_t'({bus.inst_ready, inst, cyc, strobes(), sig});
    checks++;
    if (d !== cur) begin
      errors++;
      $display("FAIL model t=%0t: got rdy=%b inst=%h cyc=%0d strb=%b sig=%b, want rdy=%b inst=%h cyc=%0d strb=%b sig=%b",
               $time, d.ready, d.inst, d.cyc, d.strb, d.sig,
               cur.ready, cur.inst, cur.cyc, cur.strb, cur.sig);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit n, input bit v, input logic [7:0] ii,
                      input bit c, input bit ir, input bit mr);
    nrst           = n;
    bus.inst_valid = v;
    bus.inst_in    = ii;
    carry          = c;
    irq            = ir;
    bus.mem_ready  = mr;
    model_step(n, v, ii, c, ir, mr);
    @(posedge clk);
    #2;
  endtask

  bit         r_n, r_v, r_ir, r_mr, r_c;
  logic [7:0] r_ii;

  initial begin
    // Reset held 3 clocks with a valid instruction pending.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h1D, 1'b0, 1'b1, 1'b1);
    chk("rst_inst", 32'(inst), 32'h0);
    chk("rst_strobes", 32'(strobes()), 32'h0);
    chk("rst_sig_cyc", 32'({sig, cyc}), 32'h0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("release_ready", 32'(bus.inst_ready), 32'h1);

    // SIG select 5.
    step(1'b1, 1'b1, 8'h1D, 1'b0, 1'b0, 1'b0);
    chk("sig_pulse", 32'(sig), 32'h20);
    chk("sig_busy", 32'(bus.inst_ready), 32'h0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("sig_clear", 32'({bus.inst_ready, sig}), 32'h100);

    // MEM store with early mem_ready (ignored) then 3 low cycles in the last step / WAIT.
    step(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1);
    chk("mem_cyc1", 32'({cyc, strobes()}), 32'h100);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mem_cyc2", 32'({cyc, strobes()}), 32'h2B0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("mem_wait_hold", 32'({cyc, strobes()}), 32'h2B0);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mem_wait_hold3", 32'({cyc, strobes()}), 32'h2B0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("mem_done", 32'({bus.inst_ready, cyc, strobes()}), 32'h400);

    // Conditional jump, then ALU and SIMPLE decode pins.
    step(1'b1, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
    chk("jmp_carry1", 32'(strobes()), 32'h00);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    chk("jmp_carry0", 32'(strobes()), 32'h40);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("jmp_pulse_end", 32'(strobes()), 32'h00);
    step(1'b1, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0);
    chk("alu_wa_wc", 32'(strobes()), 32'h03);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0);
    chk("simple_rd_wr", 32'(strobes()), 32'h0C);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset during WAIT aborts immediately.
    step(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("wait_reset", 32'({bus.inst_ready, inst, cyc, strobes()}), 32'h0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef IRQ_ENABLE_EN
    step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("irq_taken", 32'({bus.inst_ready, strobes()}), 32'h040);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("irq_masked", 32'({bus.inst_ready, strobes()}), 32'h100);
`endif

    // Randomized traffic; carry only changes between instructions.
    r_c = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r_n  = ($urandom_range(0, 99) != 0);
      r_v  = ($urandom_range(0, 2) != 0);
      r_ii = 8'($urandom);
      r_ir = ($urandom_range(0, 3) == 0);
      r_mr = ($urandom_range(0, 2) == 0);
      if (!busy) r_c = 1'($urandom_range(0, 1));
      step(r_n, r_v, r_ii, r_c, r_ir, r_mr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
